ram_seq_ctrl: RTL and testbench

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_seq_ctrl.sv | 110 +++++++++++
 tb/tb_ram_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared sizing constants and controller state encoding for the RAM
// sequencing controller.
package ram_pkg;

  localparam int DW    = 256;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/ram_seq_ctrl.sv
// Write-then-verify controller for an external synchronous RAM used as a
// circular record buffer; every accepted record is read back and compared.
module ram_seq_ctrl
  import ram_pkg::*;
#(
  parameter int DW = ram_pkg::DW,
  parameter int AW = ram_pkg::AW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          call,
  input  logic          suc,
  input  logic [DW-1:0] PD,
  input  logic [DW-1:0] q,
  output logic [AW-1:0] st,
  output logic          rdwr,
  output logic [DW-1:0] wd,
  output logic [DW-1:0] RES,
  output logic          res_vld,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic          err,
  output logic          ovf
);

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  state_t        state, next_state;
  logic [DW-1:0] pd_reg;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          accept, reject, pop, wr_inc;

  assign full   = (count == CAP);
  assign empty  = (count == '0);
  assign busy   = (state != IDLE);
  assign pop    = suc && !empty;
  assign wr_inc = (state == WRITE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Fullness is judged on the registered count, so a same-cycle pop never makes room.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (call) begin
          if (full) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = WRITE;
          end
        end
      end
      WRITE:   next_state = READ;
      READ:    next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM port signals are registered on acceptance so they are stable for the
  // whole WRITE cycle; st then holds the written slot through READ and IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st      <= '0;
      rdwr    <= 1'b0;
      wd      <= '0;
      RES     <= '0;
      res_vld <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      rdwr    <= accept;
      res_vld <= (state == CHECK);
      if (accept) begin
        st <= wr_ptr;
        wd <= PD;
      end
      if (reject) ovf <= 1'b1;
      if (wr_inc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_inc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == CHECK) begin
        RES <= q;
        if (q != pd_reg) err <= 1'b1;
      end
    end
  end

  // Reference copy of the record for the read-back compare; data only, never reset.
  always_ff @(posedge CLK) begin
    if (accept) pd_reg <= PD;
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl with a behavioural 8x256 synchronous RAM and
// queue-based scoreboards for RAM writes and read-back results.
module tb_ram_seq_ctrl;

  logic         CLK = 1'b0;
  logic         RST, call, suc;
  logic [255:0] PD, q, wd, RES;
  logic [2:0]   st;
  logic         rdwr, res_vld, busy, full, empty, err, ovf;
  logic         corrupt;
  logic [255:0] mem [8];
  logic [255:0] b255;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   slot;
    logic [255:0] data;
  } wr_t;

  wr_t          exp_wr  [$];
  logic [255:0] exp_res [$];

  ram_seq_ctrl #(.DW(256), .AW(3)) dut (
    .CLK(CLK), .RST(RST), .call(call), .suc(suc), .PD(PD), .q(q),
    .st(st), .rdwr(rdwr), .wd(wd), .RES(RES), .res_vld(res_vld),
    .busy(busy), .full(full), .empty(empty), .err(err), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (rdwr) mem[st] <= wd;
    q <= corrupt ? (mem[st] ^ b255) : mem[st];
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and every result pulse must match the head of its queue.
  always @(negedge CLK) begin
    wr_t e;
    logic [255:0] r;
    if (rdwr) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got st=%0d wd=%0h expected no write", st, wd);
      end else begin
        e = exp_wr.pop_front();
        check("write_st", {253'b0, st}, {253'b0, e.slot});
        check("write_wd", wd, e.data);
      end
    end
    if (res_vld) begin
      if (exp_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_res_vld: got RES=%0h expected no pulse", RES);
      end else begin
        r = exp_res.pop_front();
        check("res_value", RES, r);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic push(input logic [255:0] pd, input logic [2:0] slot, input bit acc,
                      input bit suc_wr, input bit hold_call);
    call = 1'b1;
    PD   = pd;
    if (acc) begin
      exp_wr.push_back('{slot, pd});
      exp_res.push_back(corrupt ? (pd ^ b255) : pd);
    end
    tick();
    check("strobe_after_call", {255'b0, rdwr}, {255'b0, acc});
    if (!hold_call) call = 1'b0;
    if (!acc) begin
      call = 1'b0;
      return;
    end
    suc = suc_wr;
    tick();
    suc = 1'b0;
    check("read_rdwr", {255'b0, rdwr}, 256'd0);
    check("read_st", {253'b0, st}, {253'b0, slot});
    tick();
    call = 1'b0;
    tick();
    check("res_vld_latency", {255'b0, res_vld}, 256'd1);
    check("idle_not_busy", {255'b0, busy}, 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b255 = {1'b1, 255'b0};
    RST = 1'b1; call = 1'b0; suc = 1'b0; PD = '0; corrupt = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    tick();
    tick();
    check("rst_st", {253'b0, st}, 256'd0);
    check("rst_rdwr", {255'b0, rdwr}, 256'd0);
    check("rst_wd", wd, 256'd0);
    check("rst_res", RES, 256'd0);
    check("rst_res_vld", {255'b0, res_vld}, 256'd0);
    check("rst_empty", {255'b0, empty}, 256'd1);
    check("rst_full", {255'b0, full}, 256'd0);
    check("rst_err", {255'b0, err}, 256'd0);
    check("rst_ovf", {255'b0, ovf}, 256'd0);
    check("rst_busy", {255'b0, busy}, 256'd0);
    RST = 1'b0;

    // pop on an empty buffer is ignored
    suc = 1'b1; tick(); suc = 1'b0;
    check("pop_empty_count", {252'b0, dut.count}, 256'd0);

    // single push, call held high while busy must not queue a second write
    push(256'h1, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    check("t1_count", {252'b0, dut.count}, 256'd1);
    check("t1_err", {255'b0, err}, 256'd0);
    check("t1_res", RES, 256'h1);

    // fill to eight, then overflow
    do_reset();
    for (int k = 0; k < 8; k++) push(256'(k), 3'(k), 1'b1, 1'b0, 1'b0);
    check("t2_full", {255'b0, full}, 256'd1);
    check("t2_count", {252'b0, dut.count}, 256'd8);
    check("t2_ovf_before", {255'b0, ovf}, 256'd0);
    push(256'd8, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_ovf", {255'b0, ovf}, 256'd1);
    check("t2_state_idle", {254'b0, dut.state}, 256'd0);

    // three pops then three pushes wrapping to slots 0..2
    for (int i = 0; i < 3; i++) begin
      suc = 1'b1; tick();
    end
    suc = 1'b0;
    check("t3_count_after_pop", {252'b0, dut.count}, 256'd5);
    check("t3_rd_ptr", {253'b0, dut.rd_ptr}, 256'd3);
    push(256'd100, 3'd0, 1'b1, 1'b0, 1'b0);
    push(256'd101, 3'd1, 1'b1, 1'b0, 1'b0);
    push(256'd102, 3'd2, 1'b1, 1'b0, 1'b0);
    check("t3_count", {252'b0, dut.count}, 256'd8);
    check("t3_full", {255'b0, full}, 256'd1);

    // corrupted read-back sets a sticky error
    do_reset();
    check("t4_ovf_cleared", {255'b0, ovf}, 256'd0);
    corrupt = 1'b1;
    push(256'hA5, 3'd0, 1'b1, 1'b0, 1'b0);
    check("t4_err_set", {255'b0, err}, 256'd1);
    corrupt = 1'b0;
    push(256'h5A, 3'd1, 1'b1, 1'b0, 1'b0);
    check("t4_err_sticky", {255'b0, err}, 256'd1);
    do_reset();
    check("t4_err_cleared", {255'b0, err}, 256'd0);

    // reset during READ aborts the transaction
    call = 1'b1; PD = 256'd77;
    exp_wr.push_back('{3'd0, 256'd77});
    tick();
    call = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    check("t5_state_idle", {254'b0, dut.state}, 256'd0);
    check("t5_rdwr", {255'b0, rdwr}, 256'd0);
    RST = 1'b0;
    check("t5_count", {252'b0, dut.count}, 256'd0);
    check("t5_empty", {255'b0, empty}, 256'd1);
    for (int i = 0; i < 5; i++) tick();

    // pop coincident with the WRITE increment
    do_reset();
    push(256'd10, 3'd0, 1'b1, 1'b0, 1'b0);
    push(256'd11, 3'd1, 1'b1, 1'b0, 1'b0);
    push(256'd12, 3'd2, 1'b1, 1'b0, 1'b0);
    push(256'd13, 3'd3, 1'b1, 1'b1, 1'b0);
    check("t6_count", {252'b0, dut.count}, 256'd3);
    check("t6_rd_ptr", {253'b0, dut.rd_ptr}, 256'd1);
    check("t6_wr_ptr", {253'b0, dut.wr_ptr}, 256'd4);

    tick();
    tick();
    check("wr_queue_drained", 256'(exp_wr.size()), 256'd0);
    check("res_queue_drained", 256'(exp_res.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
